// File: rtl/spi_master_shifter.sv
// Byte-serial SPI master shifter: turns divider half-period strobes into SCLK/MOSI/CS_n with runtime CPOL/CPHA.
// Define SPI_LSB_FIRST_EN to shift LSB first on both MOSI and MISO; the default build is MSB first.
module spi_master_shifter #(
  parameter int DATA_W     = 8,
  parameter int EDGE_CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              half_tick,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic              sclk_o,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  // Handshake: start is a level sampled only in IDLE and never in the clk where done is high;
  // done is a single-clk pulse that marks rx_data valid, and rx_data holds until the next done.

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  localparam logic [EDGE_CNT_W-1:0] LAST_EDGE = EDGE_CNT_W'(2 * DATA_W - 1);

  state_t                state_q, state_d;
  logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]     tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]     rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]     rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  sample_edge;

  function automatic logic tx_bit(input logic [DATA_W-1:0] v);
`ifdef SPI_LSB_FIRST_EN
    return v[0];
`else
    return v[DATA_W-1];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v);
`ifdef SPI_LSB_FIRST_EN
    return {1'b0, v[DATA_W-1:1]};
`else
    return {v[DATA_W-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v, input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, v[DATA_W-1:1]};
`else
    return {v[DATA_W-2:0], b};
`endif
  endfunction

  // Even edges lead, odd edges trail; CPHA picks which of the two samples MISO.
  assign sample_edge = cpha_q ? cnt_q[0] : ~cnt_q[0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (start && !done_q) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          rx_sr_d = '0;
          state_d = SETUP;
          if (!cpha) begin
            mosi_d  = tx_bit(tx_data);
            tx_sr_d = tx_shift(tx_data);
          end else begin
            tx_sr_d = tx_data;
          end
        end
      end
      SETUP: begin
        if (half_tick) begin
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (half_tick) begin
          sclk_d = ~sclk_q;
          cnt_d  = cnt_q + EDGE_CNT_W'(1);
          if (sample_edge) begin
            rx_sr_d = rx_shift(rx_sr_q, miso);
          end else if (cnt_q != LAST_EDGE) begin
            mosi_d  = tx_bit(tx_sr_q);
            tx_sr_d = tx_shift(tx_sr_q);
          end
          if (cnt_q == LAST_EDGE) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (half_tick) begin
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          rx_data_d = rx_sr_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end

  assign sclk_o  = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter: decodes the SPI bus as a slave would and compares against the words sent.
// Bit order follows SPI_LSB_FIRST_EN in the same way as the design.
module tb_spi_master_shifter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         half_tick = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         cpol = 1'b0;
  logic         cpha = 1'b0;
  logic         miso;
  logic         miso_drv = 1'b0;
  int           miso_mode = 0;  // 0 random, 1 loopback from mosi, 2 constant 1
  logic         sclk_o, mosi, cs_n, busy, done;
  logic [W-1:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tick_p = 1;
  int tick_ph = 0;

  assign miso = (miso_mode == 1) ? mosi : miso_drv;

  spi_master_shifter #(.DATA_W(W), .EDGE_CNT_W(6)) dut (
    .clk(clk), .reset(reset), .half_tick(half_tick), .start(start), .tx_data(tx_data),
    .cpol(cpol), .cpha(cpha), .miso(miso), .sclk_o(sclk_o), .mosi(mosi), .cs_n(cs_n),
    .busy(busy), .done(done), .rx_data(rx_data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_bg();
    half_tick = ((cyc % tick_p) == tick_ph);
    miso_drv  = (miso_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  // Position of the k-th bit on the wire within the word.
  function automatic int bpos(input int k);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return W - 1 - k;
`endif
  endfunction

  task automatic run_xfer(input logic [W-1:0] tx, input logic pol, input logic pha, input int mm,
                          input bit pre_idle, input bit b2b, input int stray_at, input int rst_at);
    int           ticks = 0, toggles = 0, busy_clks = 0, cs_err = 0, nbits = 0, seen = 0;
    int           lo, hi;
    bit           got_done = 0, stray_done = 0;
    logic [W-1:0] mosi_w = '0, rx_exp = '0;
    logic         sclk_prev, mosi_prev, miso_prev;
    miso_mode = mm;
    if (pre_idle) begin
      cpol  = pol;
      start = 1'b0;
      drive_bg();
      step();
      chk("idle_lvl", 32'(sclk_o), 32'(pol));
      chk("idle_cs", 32'(cs_n), 1);
    end
    tx_data = tx; cpol = pol; cpha = pha; start = 1'b1;
    drive_bg();
    step();
    start = 1'b0;
    chk("accept_busy", 32'(busy), 1);
    chk("accept_cs", 32'(cs_n), 0);
    if (!pha) chk("mosi_first", 32'(mosi), 32'(tx[bpos(0)]));
    sclk_prev = sclk_o;
    mosi_prev = mosi;
    for (int c = 0; c < 2000; c++) begin
      drive_bg();
      miso_prev = (mm == 1) ? mosi : miso_drv;
      if (stray_at >= 0 && toggles == stray_at && !stray_done) begin
        start = 1'b1;
        tx_data = W'($urandom);
        stray_done = 1;
      end else begin
        start = 1'b0;
      end
      cpol = 1'($urandom);
      cpha = 1'($urandom);
      if (rst_at >= 0 && toggles == rst_at) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_cs", 32'(cs_n), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sclk", 32'(sclk_o), 0);
        chk("rst_rx", 32'(rx_data), 0);
        chk("rst_mosi", 32'(mosi), 0);
        cpol = pol;
        for (int k = 0; k < 100; k++) begin
          drive_bg();
          step();
          if (done) seen++;
        end
        chk("rst_no_done", seen, 0);
        return;
      end
      step();
      if (half_tick) ticks++;
      if (busy) busy_clks++;
      if (sclk_o !== sclk_prev) begin
        if ((toggles % 2) == int'(pha) && nbits < W) begin
          mosi_w[bpos(nbits)] = mosi_prev;
          rx_exp[bpos(nbits)] = miso_prev;
          nbits++;
        end
        toggles++;
      end
      sclk_prev = sclk_o;
      mosi_prev = mosi;
      if (done) begin
        got_done = 1;
        break;
      end
      if (cs_n) cs_err++;
    end
    start = 1'b0;
    cpol = pol;
    lo = (2 * W + 1) * tick_p + 1;
    hi = (2 * W + 2) * tick_p;
    chk("done_seen", 32'(got_done), 1);
    chk("ticks", ticks, 2 * W + 2);
    chk("toggles", toggles, 2 * W);
    chk("mosi_seq", 32'(mosi_w), 32'(tx));
    chk("rx_data", 32'(rx_data), 32'(rx_exp));
    chk("end_lvl", 32'(sclk_o), 32'(pol));
    chk("cs_low_xfer", cs_err, 0);
    chk("done_cs", 32'(cs_n), 1);
    chk("done_busy", 32'(busy), 0);
    chk("busy_len", 32'((busy_clks + 1) >= lo && (busy_clks + 1) <= hi), 1);
    if (b2b) begin
      start = 1'b1;
      tx_data = W'($urandom);
    end
    drive_bg();
    step();
    start = 1'b0;
    chk("done_pulse", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    bit b2b, prev_b2b;
    int stray;
    reset = 1'b0;
    repeat (3) step();
    chk("reset_cs", 32'(cs_n), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rx", 32'(rx_data), 0);
    chk("reset_sclk", 32'(sclk_o), 0);
    chk("reset_mosi", 32'(mosi), 0);
    reset = 1'b1;

    tick_p = 1; tick_ph = 0;
    run_xfer(8'hA5, 1'b0, 1'b0, 1, 1, 0, -1, -1);
    chk("mode0_rx_a5", 32'(rx_data), 32'h A5);
    run_xfer(8'h3C, 1'b1, 1'b1, 2, 1, 0, -1, -1);
    chk("mode3_rx_ff", 32'(rx_data), 32'h FF);

    tick_p = 4; tick_ph = 1;
    run_xfer(8'h81, 1'b0, 1'b1, 0, 1, 1, -1, -1);
    run_xfer(W'($urandom), 1'b0, 1'b1, 1, 0, 0, -1, -1);

    tick_p = 2; tick_ph = 0;
    run_xfer(8'h5A, 1'b0, 1'b0, 1, 1, 0, 5, -1);
    chk("stray_rx_5a", 32'(rx_data), 32'h 5A);

    tick_p = 1; tick_ph = 0;
    run_xfer(8'h01, 1'b0, 1'b0, 1, 1, 0, -1, -1);
    chk("loop_rx_01", 32'(rx_data), 32'h 01);
    run_xfer(8'hC3, 1'b1, 1'b0, 0, 1, 0, -1, 9);

    prev_b2b = 0;
    repeat (30) begin
      tick_p  = $urandom_range(1, 4);
      tick_ph = $urandom_range(0, tick_p - 1);
      b2b     = ($urandom_range(0, 3) == 0);
      stray   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * W - 1) : -1;
      run_xfer(W'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2), !prev_b2b, b2b, stray, -1);
      prev_b2b = b2b;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_master_shifter.md
Name: spi_master_shifter

Overview:
- Byte-serial SPI master engine; sits directly downstream of the SPI clock divider stage.
- Consumes a half-period strobe from the divider and produces SCLK, MOSI and CS_n with runtime-selectable CPOL/CPHA.
- Samples MISO and returns the received word with a one-cycle done pulse to the host-side controller.
- All logic runs in the clk domain; SCLK is a registered output, never used as a clock.

Parameters:
- DATA_W, 8, bits per transfer (2..32).
- EDGE_CNT_W, 6, width of the internal edge counter; must satisfy 2^EDGE_CNT_W >= 2*DATA_W.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- half_tick  input  1  one-clk strobe per SCLK half-period, from the divider stage.
- start  input  1  transfer request, sampled in IDLE only.
- tx_data  input  DATA_W  word to send, latched on start acceptance.
- cpol  input  1  SCLK idle level, latched on start acceptance.
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on start acceptance.
- miso  input  1  serial data from slave (already synchronised upstream).
- sclk_o  output  1  SPI clock.
- mosi  output  1  serial data to slave.
- cs_n  output  1  chip select, active low.
- busy  output  1  high from start acceptance until return to IDLE.
- done  output  1  one-clk pulse when rx_data becomes valid.
- rx_data  output  DATA_W  last received word, held until the next done.

Behaviour:
- Reset (reset==0 at posedge clk) sets all of the following; asserting reset mid-transfer aborts immediately with no done pulse:
  - sclk_o=0, mosi=0, cs_n=1, busy=0, done=0, rx_data=0;
  - state=IDLE, edge counter=0, shift registers=0.
- IDLE:
  - sclk_o <= cpol input every clk.
  - start=1 → latch tx_data/cpol/cpha, cs_n<=0, busy<=1, go to SETUP.
  - CPHA=0: mosi <= first data bit in the same cycle as acceptance.
  - A half_tick coincident with start is ignored.
- SETUP: wait for the next half_tick, then go to XFER with edge counter=0. The edge counter increments once per half_tick in XFER.
- XFER: each half_tick toggles sclk_o.
  - Even count = leading edge; odd count = trailing edge.
  - CPHA=0: leading edge samples miso into the rx shift register; trailing edge drives the next bit to mosi. The trailing edge of the final bit drives nothing new.
  - CPHA=1: leading edge drives the next bit to mosi (first bit on edge 0); trailing edge samples miso.
  - After edge 2*DATA_W-1 → HOLD. sclk_o is back at latched cpol.
- HOLD: on the next half_tick, take all of the following actions, then go to IDLE:
  - cs_n<=1, busy<=0;
  - rx_data<=rx shift register;
  - done<=1 for exactly one clk.
- Tick timing:
  - Transfer length = 2*DATA_W + 2 half_ticks from acceptance to done.
  - There is no timeout; if half_tick stops, the state machine holds.
- Start handling:
  - start while busy=1 is ignored; it is not queued.
  - start in the same clk as done is ignored; the earliest new acceptance is the clk after done.
- Shift order is MSB first unless the optional feature is enabled.
- mosi holds its last value in IDLE.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- When defined: tx shifts out bit 0 first; rx fills from the MSB end so the first received bit lands in rx_data[0].
- When undefined: MSB-first for both tx and rx.
- Port list and timing are identical in both builds.

Test Plan:
- Mode 0, DATA_W=8, half_tick every clk, tx_data=0xA5, miso tied to mosi:
  - exactly 16 sclk_o toggles, idle level 0;
  - done after 18 half_ticks;
  - rx_data=0xA5, cs_n low for the whole transfer.
- Mode 3 (cpol=1, cpha=1), tx_data=0x3C, miso=1:
  - sclk_o idles 1 and ends at 1;
  - mosi bit sequence 0,0,1,1,1,1,0,0 on leading edges;
  - rx_data=0xFF.
- half_tick every 4 clks, mode 1, tx_data=0x81:
  - busy high for 72±3 clks;
  - done is a single-clk pulse;
  - second start 1 clk after done is accepted.
- Start pulsed at edge 5 of an active 0x5A transfer: ignored; done fires once and rx_data reflects only the first transfer.
- reset=0 held for 1 clk at edge 9 of a transfer: next clk cs_n=1, busy=0, sclk_o=0, rx_data=0x00, and no done is ever seen.
- With SPI_LSB_FIRST_EN, mode 0, tx_data=0x01: mosi=1 on the first leading edge then 0; loopback rx_data=0x01.
